// File: rtl/ntt_multilane_sequencer.sv
// ntt_multilane_sequencer
// Control engine for a multi-lane NTT datapath. It walks the stages of a
// runtime-sized transform (forward CT order or inverse GS order), issues
// per-lane read addresses and twiddle indices, and replays the issued
// addresses through a D-deep delay line to produce write-back strobes.
// A D-cycle drain between stages guarantees that every write of one stage
// lands before the next stage reads the register file.
module ntt_multilane_sequencer #(
    parameter int LOG_N      = 8,
    parameter int LANES      = 2,
    parameter int BF_LATENCY = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       fwd_ntt_i,
    input  logic [$clog2(LOG_N+1)-1:0] param_log_n_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       cfg_err_o,
    output logic                       fwd_o,
    output logic [LANES-1:0]           rd_en_o,
    output logic [LANES*LOG_N-1:0]     raddr1_o,
    output logic [LANES*LOG_N-1:0]     raddr2_o,
    output logic [LANES*LOG_N-1:0]     tw_idx_o,
    output logic [LANES-1:0]           bf_valid_o,
    output logic [LANES-1:0]           we_o,
    output logic [LANES*LOG_N-1:0]     waddr1_o,
    output logic [LANES*LOG_N-1:0]     waddr2_o
);

    localparam int LW       = $clog2(LOG_N + 1);
    localparam int D        = BF_LATENCY + 1;
    localparam int DW       = $clog2(D + 1);
    localparam int LANE_LOG = $clog2(LANES);
    localparam int AW       = LANES * LOG_N;

    localparam logic [LOG_N-1:0] ONE_N   = LOG_N'(1);
    localparam logic [LOG_N-1:0] LANES_N = LOG_N'(LANES);
    localparam logic [LW-1:0]    ONE_L   = LW'(1);
    localparam logic [LW-1:0]    MIN_L   = LW'(LANE_LOG + 1);
    localparam logic [LW-1:0]    MAX_L   = LW'(LOG_N);
    localparam logic [DW-1:0]    DRAIN_N = DW'(D);
    localparam logic [DW-1:0]    ONE_D   = DW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Lower butterfly address: group g = k >> sh, len = 1 << sh,
    // addr1 = 2*g*len + (k & (len-1)), with sh = L-1-s.
    function automatic logic [LOG_N-1:0] calc_addr1(input logic [LOG_N-1:0] k,
                                                    input logic [LW-1:0]    sh);
        logic [LOG_N-1:0] g;
        logic [LOG_N-1:0] len;
        g   = k >> sh;
        len = ONE_N << sh;
        return (g << (sh + ONE_L)) + (k & (len - ONE_N));
    endfunction

    // Twiddle index: (1 << s) + g.
    function automatic logic [LOG_N-1:0] calc_tw(input logic [LOG_N-1:0] k,
                                                 input logic [LW-1:0]    sh,
                                                 input logic [LW-1:0]    s);
        return (ONE_N << s) + (k >> sh);
    endfunction

    // FSM and sequencing state
    logic [1:0]       state_q,  state_d;
    logic [LW-1:0]    l_q,      l_d;
    logic             fwd_q,    fwd_d;
    logic [LW-1:0]    stage_q,  stage_d;
    logic [LW-1:0]    left_q,   left_d;
    logic [LOG_N-1:0] kbase_q,  kbase_d;
    logic [DW-1:0]    drain_q,  drain_d;
    logic             cfg_err_d;

    // Registered issue outputs
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             cfg_err_q;
    logic [LANES-1:0] rd_en_q,  rd_en_d;
    logic [AW-1:0]    raddr1_q, raddr1_d;
    logic [AW-1:0]    raddr2_q, raddr2_d;
    logic [AW-1:0]    tw_q,     tw_d;

    // Write-back delay line (entry 0 doubles as the butterfly-valid stage)
    logic [LANES-1:0] pipe_v_q  [D];
    logic [AW-1:0]    pipe_a1_q [D];
    logic [AW-1:0]    pipe_a2_q [D];

    logic             abort_s;
    logic             legal_s;
    logic             last_k_s;
    logic [LOG_N-1:0] half_n_s;
    logic [LW-1:0]    sh_s;

    assign abort_s  = abort_i && (state_q != ST_IDLE);
    assign legal_s  = (param_log_n_i >= MIN_L) && (param_log_n_i <= MAX_L);
    assign half_n_s = ONE_N << (l_q - ONE_L);
    assign last_k_s = (kbase_q + LANES_N) == half_n_s;
    assign sh_s     = l_d - stage_d - ONE_L;

    // Next-state logic: stage walk, k stepping, drain countdown, abort priority
    always_comb begin
        state_d   = state_q;
        l_d       = l_q;
        fwd_d     = fwd_q;
        stage_d   = stage_q;
        left_d    = left_q;
        kbase_d   = kbase_q;
        drain_d   = drain_q;
        cfg_err_d = 1'b0;
        if (abort_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (legal_s) begin
                            state_d = ST_ISSUE;
                            l_d     = param_log_n_i;
                            fwd_d   = fwd_ntt_i;
                            stage_d = fwd_ntt_i ? '0 : (param_log_n_i - ONE_L);
                            left_d  = param_log_n_i - ONE_L;
                            kbase_d = '0;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (last_k_s) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_N;
                    end else begin
                        kbase_d = kbase_q + LANES_N;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == ONE_D) begin
                        if (left_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ISSUE;
                            stage_d = fwd_q ? (stage_q + ONE_L) : (stage_q - ONE_L);
                            left_d  = left_q - ONE_L;
                            kbase_d = '0;
                        end
                    end else begin
                        drain_d = drain_q - ONE_D;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Issue datapath: outputs for the next cycle are derived from the next state
    always_comb begin
        busy_d   = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        done_d   = (state_d == ST_DONE);
        rd_en_d  = '0;
        raddr1_d = raddr1_q;
        raddr2_d = raddr2_q;
        tw_d     = tw_q;
        if (state_d == ST_ISSUE) begin
            rd_en_d = '1;
            for (int l = 0; l < LANES; l++) begin
                raddr1_d[l*LOG_N +: LOG_N] = calc_addr1(kbase_d + LOG_N'(l), sh_s);
                raddr2_d[l*LOG_N +: LOG_N] = calc_addr1(kbase_d + LOG_N'(l), sh_s)
                                             + (ONE_N << sh_s);
                tw_d[l*LOG_N +: LOG_N]     = calc_tw(kbase_d + LOG_N'(l), sh_s, stage_d);
            end
        end else begin
            rd_en_d = '0;
        end
    end

    // FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            fwd_q   <= 1'b0;
            stage_q <= '0;
            left_q  <= '0;
            kbase_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            fwd_q   <= fwd_d;
            stage_q <= stage_d;
            left_q  <= left_d;
            kbase_q <= kbase_d;
            drain_q <= drain_d;
        end
    end

    // Registered status and read-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            rd_en_q   <= '0;
            raddr1_q  <= '0;
            raddr2_q  <= '0;
            tw_q      <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            rd_en_q   <= rd_en_d;
            raddr1_q  <= raddr1_d;
            raddr2_q  <= raddr2_d;
            tw_q      <= tw_d;
        end
    end

    // Write-back delay line; abort kills every in-flight valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                pipe_v_q[i]  <= '0;
                pipe_a1_q[i] <= '0;
                pipe_a2_q[i] <= '0;
            end
        end else begin
            pipe_v_q[0]  <= abort_s ? '0 : rd_en_q;
            pipe_a1_q[0] <= raddr1_q;
            pipe_a2_q[0] <= raddr2_q;
            for (int i = 1; i < D; i++) begin
                pipe_v_q[i]  <= abort_s ? '0 : pipe_v_q[i-1];
                pipe_a1_q[i] <= pipe_a1_q[i-1];
                pipe_a2_q[i] <= pipe_a2_q[i-1];
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign cfg_err_o  = cfg_err_q;
    assign fwd_o      = fwd_q;
    assign rd_en_o    = rd_en_q;
    assign raddr1_o   = raddr1_q;
    assign raddr2_o   = raddr2_q;
    assign tw_idx_o   = tw_q;
    assign bf_valid_o = pipe_v_q[0];
    assign we_o       = pipe_v_q[D-1];
    assign waddr1_o   = pipe_a1_q[D-1];
    assign waddr2_o   = pipe_a2_q[D-1];

endmodule
